edge_event_arbiter: RTL and testbench

Collects rising edges from N asynchronous input lines (keypad/button/strobe signals) and presents them one at a time to a single downstream consumer over a valid/ready port. Each channel gets its own synchronizer and rising-edge detector, plus a one-deep pending latch. A round-robin scheduler shares the single event port among the channels. It sits between the raw board inputs and the recognizer control FSM, so the FSM only ever sees one tagged, synchronized event at a time.

---
 rtl/edge_arb_pkg.sv | 14 +
 rtl/edge_event_arbiter_rr_pick.sv | 35 +++
 rtl/edge_event_arbiter.sv | 159 +++++++++++++++
 tb/tb_edge_event_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// Shared types and constants for the edge event arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package edge_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam int unsigned              OVR_CNT_W   = 8;
    localparam logic [OVR_CNT_W-1:0]     OVR_CNT_MAX = 8'd255;

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Round-robin selector: first set request strictly after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when to consume the grant.
module rr_pick #(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    localparam logic [ID_W:0] N_W = (ID_W+1)'(N_CH);

    logic [ID_W:0] sum;

    // Scan farthest offset first so the nearest requester after 'last' overwrites and wins.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        sum     = '0;
        for (int off = N_CH; off >= 1; off--) begin
            sum = {1'b0, last} + (ID_W+1)'(off);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            if (req[sum[ID_W-1:0]]) begin
                gnt_id  = sum[ID_W-1:0];
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Synchronizes N async lines, latches one rising edge per channel, and offers them round-robin.
// Latency: line high at sample k -> pending at k+2 -> evt_valid/evt_id registered at k+3.
// Backpressure: evt_valid holds until evt_ready; extra edges on a pending channel set sticky overrun.
// Optional build macro OVERRUN_CNT_EN adds the saturating ovr_count port.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ID_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [N_CH-1:0]      sig,
    input  logic [N_CH-1:0]      ch_enable,
    output logic                 evt_valid,
    output logic [ID_W-1:0]      evt_id,
    input  logic                 evt_ready,
    output logic [N_CH-1:0]      pending,
    output logic [N_CH-1:0]      overrun,
    input  logic                 clr_overrun
`ifdef OVERRUN_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0] ovr_count
`endif
);

    logic [N_CH-1:0] rise_w;
    logic [N_CH-1:0] req_w;
    logic [N_CH-1:0] gnt_clr;
    logic [N_CH-1:0] pend_keep;
    logic [N_CH-1:0] ovr_set;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] ovr_q, ovr_d;
    logic [ID_W-1:0] evt_id_q, evt_id_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [ID_W-1:0] gnt_id_w;
    logic            gnt_any_w;
    arb_state_t      state_q, state_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic sync1_q, sync2_q, prev_q;

        // Two-flop synchronizer plus history flop, reset high so a line held high through reset is not an edge.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                prev_q  <= 1'b1;
            end else begin
                sync1_q <= sig[g];
                sync2_q <= sync1_q;
                prev_q  <= sync2_q;
            end
        end

        assign rise_w[g] = sync2_q & ~prev_q;
    end

    // Disabled channels are never offered, even in the cycle their pending bit is being dropped.
    assign req_w = pend_q & ch_enable;

    rr_pick #(
        .N_CH (N_CH),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req     (req_w),
        .last    (last_q),
        .gnt_id  (gnt_id_w),
        .gnt_any (gnt_any_w)
    );

    // Grant in IDLE, or on acceptance in OFFER so back-to-back events leave no bubble.
    always_comb begin
        state_d  = state_q;
        evt_id_d = evt_id_q;
        last_d   = last_q;
        gnt_clr  = '0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any_w) begin
                    evt_id_d = gnt_id_w;
                    last_d   = gnt_id_w;
                    gnt_clr  = {{(N_CH-1){1'b0}}, 1'b1} << gnt_id_w;
                    state_d  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (gnt_any_w) begin
                        evt_id_d = gnt_id_w;
                        last_d   = gnt_id_w;
                        gnt_clr  = {{(N_CH-1){1'b0}}, 1'b1} << gnt_id_w;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An edge landing on the just-granted channel is a fresh event, so overrun compares against the post-grant value.
    always_comb begin
        pend_keep = pend_q & ~gnt_clr;
        ovr_set   = rise_w & ch_enable & pend_keep;
        pend_d    = ch_enable & (pend_keep | rise_w);
        ovr_d     = (clr_overrun ? '0 : ovr_q) | ovr_set;
    end

    // Arbiter state, offered id, round-robin pointer and per-channel latches.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            evt_id_q <= '0;
            last_q   <= ID_W'(N_CH - 1);
            pend_q   <= '0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            evt_id_q <= evt_id_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            ovr_q    <= ovr_d;
        end
    end

    assign evt_valid = (state_q == OFFER);
    assign evt_id    = evt_id_q;
    assign pending   = pend_q;
    assign overrun   = ovr_q;

`ifdef OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_inc;
    logic [OVR_CNT_W:0]   ovr_sum;
    logic [OVR_CNT_W-1:0] cnt_q, cnt_d;

    // Add this cycle's overrun population; a clear restarts from this cycle's count, then saturate.
    always_comb begin
        ovr_inc = '0;
        for (int i = 0; i < N_CH; i++) begin
            ovr_inc = ovr_inc + OVR_CNT_W'(ovr_set[i]);
        end
        ovr_sum = (clr_overrun ? '0 : {1'b0, cnt_q}) + {1'b0, ovr_inc};
        cnt_d   = (ovr_sum > {1'b0, OVR_CNT_MAX}) ? OVR_CNT_MAX : ovr_sum[OVR_CNT_W-1:0];
    end

    // Overrun counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ovr_count = cnt_q;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with hand-computed expectations.
// Latency: checks the k+3 offer latency and zero-bubble back-to-back grants.
// Backpressure: holds evt_ready low to build pending/overrun state.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [3:0] sig;
    logic [3:0] ch_enable;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       clr_overrun;
`ifdef OVERRUN_CNT_EN
    logic [7:0] ovr_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(
        .N_CH (4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .sig         (sig),
        .ch_enable   (ch_enable),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .evt_ready   (evt_ready),
        .pending     (pending),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
`ifdef OVERRUN_CNT_EN
        ,
        .ovr_count   (ovr_count)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int         seen;
        logic [3:0] vh;
        logic [3:0] p2;
        sig = 4'hF; ch_enable = 4'hF; evt_ready = 1'b0; clr_overrun = 1'b0; n_rst = 1'b0;
        tick(3);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
        checks++; if (evt_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", evt_id); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun: got %b want 0000", overrun); end
`ifdef OVERRUN_CNT_EN
        checks++; if (ovr_count !== 8'd0) begin errors++; $display("FAIL reset_ovr_count: got %0d want 0", ovr_count); end
`endif
        n_rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (evt_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL held_high_no_event: got %0d valid cycles want 0", seen); end
        sig[2] = 1'b0;
        tick(5);
        sig[2] = 1'b1;
        p2 = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            vh[c] = evt_valid;
            if (c == 2) p2 = pending;
        end
        checks++; if (vh !== 4'b1000) begin errors++; $display("FAIL latency_valid: got %b want 1000", vh); end
        checks++; if (p2 !== 4'b0100) begin errors++; $display("FAIL latency_pending: got %b want 0100", p2); end
        checks++; if (evt_id !== 2'd2) begin errors++; $display("FAIL latency_id: got %0d want 2", evt_id); end
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL accept_idle: got %b want 0", evt_valid); end
    endtask

    task automatic test_round_robin();
        logic [6:0] v;
        logic [1:0] ids [7];
        sig = 4'h0; n_rst = 1'b0; tick(2); n_rst = 1'b1; tick(5);
        evt_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            sig = 4'b1011;
            for (int c = 0; c < 7; c++) begin
                tick(1);
                v[c]   = evt_valid;
                ids[c] = evt_id;
            end
            checks++; if (v !== 7'b0111000) begin errors++; $display("FAIL rr_valid_rep%0d: got %b want 0111000", rep, v); end
            checks++; if (ids[3] !== 2'd0) begin errors++; $display("FAIL rr_first_rep%0d: got %0d want 0", rep, ids[3]); end
            checks++; if (ids[4] !== 2'd1) begin errors++; $display("FAIL rr_second_rep%0d: got %0d want 1", rep, ids[4]); end
            checks++; if (ids[5] !== 2'd3) begin errors++; $display("FAIL rr_third_rep%0d: got %0d want 3", rep, ids[5]); end
            sig = 4'h0;
            tick(5);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_overrun();
        sig = 4'b0001; tick(5);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin errors++; $display("FAIL ovr_setup: got v=%b id=%0d want v=1 id=0", evt_valid, evt_id); end
        for (int p = 0; p < 3; p++) begin
            sig[1] = 1'b1; tick(2);
            sig[1] = 1'b0; tick(2);
        end
        tick(3);
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovr_pending: got %b want 0010", pending); end
        checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_flag: got %b want 0010", overrun); end
`ifdef OVERRUN_CNT_EN
        checks++; if (ovr_count !== 8'd2) begin errors++; $display("FAIL ovr_count: got %0d want 2", ovr_count); end
`endif
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin errors++; $display("FAIL ovr_hold: got v=%b id=%0d want v=1 id=0", evt_valid, evt_id); end
        clr_overrun = 1'b1; tick(1); clr_overrun = 1'b0;
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clear: got %b want 0000", overrun); end
`ifdef OVERRUN_CNT_EN
        checks++; if (ovr_count !== 8'd0) begin errors++; $display("FAIL ovr_count_clear: got %0d want 0", ovr_count); end
`endif
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovr_clear_pending: got %b want 0010", pending); end
        evt_ready = 1'b1; tick(1);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin errors++; $display("FAIL ovr_drain: got v=%b id=%0d want v=1 id=1", evt_valid, evt_id); end
        tick(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_idle: got %b want 0", evt_valid); end
        sig = 4'h0; tick(5);
    endtask

    task automatic test_regrant_same_cycle();
        sig = 4'b0001; tick(5);
        sig[2] = 1'b1; tick(2); sig[2] = 1'b0; tick(5);
        checks++; if (pending !== 4'b0100 || evt_id !== 2'd0) begin errors++; $display("FAIL regrant_setup: got p=%b id=%0d want p=0100 id=0", pending, evt_id); end
        sig[2] = 1'b1; tick(2);
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin errors++; $display("FAIL regrant_offer: got v=%b id=%0d want v=1 id=2", evt_valid, evt_id); end
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL regrant_pending: got %b want 0100", pending); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL regrant_no_overrun: got %b want 0000", overrun); end
        tick(1);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin errors++; $display("FAIL regrant_hold: got v=%b id=%0d want v=1 id=2", evt_valid, evt_id); end
        evt_ready = 1'b1; tick(1);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || pending !== 4'b0000) begin errors++; $display("FAIL regrant_second: got v=%b id=%0d p=%b want v=1 id=2 p=0000", evt_valid, evt_id, pending); end
        tick(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL regrant_idle: got %b want 0", evt_valid); end
        sig = 4'h0; tick(5);
    endtask

    task automatic test_disable();
        sig = 4'b0001; tick(5);
        sig[3] = 1'b1; tick(5);
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL dis_setup: got %b want 1000", pending); end
        ch_enable[3] = 1'b0; tick(1);
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL dis_clear: got %b want 0000", pending); end
        sig[3] = 1'b0; tick(3); sig[3] = 1'b1; tick(5);
        checks++; if (pending !== 4'b0000 || overrun !== 4'b0000) begin errors++; $display("FAIL dis_edge_ignored: got p=%b o=%b want 0000/0000", pending, overrun); end
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL dis_no_id3: got v=%b id=%0d want v=0", evt_valid, evt_id); end
        ch_enable = 4'hF; sig = 4'h0; tick(5);
        checks++; if (evt_valid !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL dis_reenable: got v=%b p=%b want 0/0000", evt_valid, pending); end
    endtask

    task automatic test_reset_mid_offer();
        int seen;
        sig = 4'b0001; tick(5);
        sig = 4'b0111; tick(5);
        checks++; if (pending !== 4'b0110 || evt_valid !== 1'b1) begin errors++; $display("FAIL rst_setup: got p=%b v=%b want 0110/1", pending, evt_valid); end
        n_rst = 1'b0; #1;
        checks++; if (evt_valid !== 1'b0 || evt_id !== 2'd0) begin errors++; $display("FAIL rst_async_out: got v=%b id=%0d want 0/0", evt_valid, evt_id); end
        checks++; if (pending !== 4'b0000 || overrun !== 4'b0000) begin errors++; $display("FAIL rst_async_state: got p=%b o=%b want 0000/0000", pending, overrun); end
        tick(2); n_rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (evt_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_no_spurious: got %0d valid cycles want 0", seen); end
        sig[3] = 1'b1; tick(4);
        checks++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin errors++; $display("FAIL rst_new_event: got v=%b id=%0d want v=1 id=3", evt_valid, evt_id); end
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_overrun();
        test_regrant_same_cycle();
        test_disable();
        test_reset_mid_offer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
